lfsr_vector_gen: RTL and testbench

Parametrised multi-channel LFSR stimulus generator; successor to the fixed 4-bit lfsr used three-wide to drive random instruction_bus vectors.
NUM_CH channels of WIDTH bits, with runtime seed load, independent or cascade (odometer) stepping, burst-length control, and a valid/ready output handshake.
Sits in the testbench/stimulus layer, driving the cpu instruction bus or any other wide random input.

---
 rtl/lfsr_pkg.sv | 63 ++++++
 rtl/lfsr_vector_gen_if.sv | 36 +++
 rtl/lfsr_channel.sv | 67 ++++++
 rtl/lfsr_vector_gen.sv | 154 +++++++++++++++
 tb/tb_lfsr_vector_gen.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared types, tap masks and the LFSR step function for the
//               multi-channel LFSR vector generator.
//               - gen_state_e  : generator FSM encoding (IDLE / RUN / DONE)
//               - c_poly_w3..8 : maximal-length Fibonacci tap masks
//               - default_poly : tap mask lookup by channel width
//               - lfsr_next    : one Fibonacci step, {s << 1, ^(s & poly)}
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    // Widest channel the step function handles. Channels zero-extend
    // their state and tap mask to this width and keep the low bits of
    // the result.
    localparam int c_lfsr_max_w = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gen_state_e;

    // Tap masks for next = {s[W-2:0], ^(s & POLY)}; each one is maximal
    // length (period 2^W - 1).
    localparam logic [2:0] c_poly_w3 = 3'b110;       // x^3+x^2+1
    localparam logic [3:0] c_poly_w4 = 4'b1100;      // x^4+x^3+1
    localparam logic [4:0] c_poly_w5 = 5'b10100;     // x^5+x^3+1
    localparam logic [5:0] c_poly_w6 = 6'b110000;    // x^6+x^5+1
    localparam logic [6:0] c_poly_w7 = 7'b1100000;   // x^7+x^6+1
    localparam logic [7:0] c_poly_w8 = 8'b10111000;  // x^8+x^6+x^5+x^4+1

    // Tap mask for a given width. Widths without a table entry get
    // x^W+x^(W-1)+1: it never locks up from a non-zero seed, but it is
    // not guaranteed to be maximal length.
    function automatic logic [c_lfsr_max_w-1:0] default_poly(input int width);
        logic [c_lfsr_max_w-1:0] v_poly;
        case (width)
            3:       v_poly = c_lfsr_max_w'(c_poly_w3);
            4:       v_poly = c_lfsr_max_w'(c_poly_w4);
            5:       v_poly = c_lfsr_max_w'(c_poly_w5);
            6:       v_poly = c_lfsr_max_w'(c_poly_w6);
            7:       v_poly = c_lfsr_max_w'(c_poly_w7);
            8:       v_poly = c_lfsr_max_w'(c_poly_w8);
            default: v_poly = (c_lfsr_max_w'(1) << (width - 1))
                            | (c_lfsr_max_w'(1) << (width - 2));
        endcase
        return v_poly;
    endfunction

    // One Fibonacci step. The operands are zero-extended, so the upper
    // bits add nothing to the feedback XOR, and the low W bits of the
    // result equal {s[W-2:0], ^(s & poly)}.
    function automatic logic [c_lfsr_max_w-1:0] lfsr_next(
        input logic [c_lfsr_max_w-1:0] state,
        input logic [c_lfsr_max_w-1:0] poly
    );
        return {state[c_lfsr_max_w-2:0], ^(state & poly)};
    endfunction

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr_vector_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_vector_gen_if
// Description : Output stream of the LFSR vector generator.
//               out_data  : NUM_CH*WIDTH, channel k at [k*WIDTH +: WIDTH]
//               out_valid : vector available
//               out_ready : consumer accepts when out_valid & out_ready
//               wrap_out  : NUM_CH per-channel wrap flags, aligned with out_data
//               master = generator side, slave = consumer side.
//               WIDTH and NUM_CH must match the generator instance.
// Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_vector_gen_if #(
    parameter int WIDTH  = 4,
    parameter int NUM_CH = 3
);
    logic [NUM_CH*WIDTH-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [NUM_CH-1:0]       wrap_out;

    modport master (
        output out_data,
        output out_valid,
        output wrap_out,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  wrap_out,
        output out_ready
    );
endinterface : lfsr_vector_gen_if
`default_nettype wire

// File: rtl/lfsr_channel.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_channel
// Description : One Fibonacci LFSR channel with a seed register.
//               clk, rst : clock, asynchronous active-high reset
//               load     : load seed into the seed and state registers
//               seed     : seed value; zero is replaced by 0...01
//               step     : advance the state by one LFSR step
//               state    : current (registered) state
//               wrap     : next state equals the seed; only meaningful
//                          in a cycle where step is high
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_channel
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(default_poly(WIDTH))
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              load,
    input  wire [WIDTH-1:0]  seed,
    input  wire              step,
    output logic [WIDTH-1:0] state,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] seed_q,  seed_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_seed_fix;

    // The all-zero state is a fixed point of the LFSR, so a zero seed
    // is replaced by 0...01.
    assign w_seed_fix = (seed == '0) ? c_one : seed;

    assign w_next = WIDTH'(lfsr_next(c_lfsr_max_w'(state_q), c_lfsr_max_w'(POLY)));

    always_comb begin
        seed_d  = seed_q;
        state_d = state_q;
        if (load) begin
            seed_d  = w_seed_fix;
            state_d = w_seed_fix;
        end else if (step) begin
            state_d = w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_q  <= c_one;
            state_q <= c_one;
        end else begin
            seed_q  <= seed_d;
            state_q <= state_d;
        end
    end

    assign state = state_q;
    assign wrap  = (w_next == seed_q);

endmodule : lfsr_channel
`default_nettype wire

// File: rtl/lfsr_vector_gen.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_vector_gen
// Description : Multi-channel LFSR stimulus generator with seed load,
//               independent or cascade (odometer) stepping, burst-length
//               control and a valid/ready output stream.
//               clk, rst  : clock, asynchronous active-high reset
//               start     : pulse, begins a burst from IDLE
//               stop      : pulse, aborts a burst in RUN (no done pulse)
//               cascade   : 0 = all channels step, 1 = odometer; latched at start
//               burst_len : vectors per burst, latched at start; 0 = unbounded
//               seed_load : pulse, loads seed_data (IDLE only)
//               seed_data : channel k seed at [k*WIDTH +: WIDTH]
//               busy      : high in RUN
//               done      : one-cycle pulse after the final accept
//               out_if    : out_data / out_valid / out_ready / wrap_out
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_vector_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH  = 4,
    parameter int               NUM_CH = 3,
    parameter logic [WIDTH-1:0] POLY   = WIDTH'(default_poly(WIDTH)),
    parameter int               CNT_W  = 16
) (
    input  wire                     clk,
    input  wire                     rst,
    input  wire                     start,
    input  wire                     stop,
    input  wire                     cascade,
    input  wire [CNT_W-1:0]         burst_len,
    input  wire                     seed_load,
    input  wire [NUM_CH*WIDTH-1:0]  seed_data,
    output logic                    busy,
    output logic                    done,
    lfsr_vector_gen_if.master       out_if
);

    gen_state_e          state_q,   state_d;
    logic                cascade_q, cascade_d;
    logic [CNT_W-1:0]    len_q,     len_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [NUM_CH-1:0]   wrap_q,    wrap_d;

    logic                    w_accept;
    logic                    w_load;
    logic                    w_last;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic [NUM_CH-1:0]       w_step;
    logic [NUM_CH-1:0]       w_wrap;
    logic [NUM_CH*WIDTH-1:0] w_state;

    assign w_accept  = (state_q == RUN) && out_if.out_ready;
    assign w_load    = (state_q == IDLE) && seed_load;
    assign w_cnt_inc = cnt_q + CNT_W'(1);
    // The count never exceeds a non-zero burst_len, so the increment
    // cannot overflow on this path.
    assign w_last    = w_accept && (len_q != '0) && (w_cnt_inc == len_q);

    // ------------------------------------------------------------------
    // Channels and step enables. In cascade mode channel k steps when
    // every lower channel steps and wraps in this cycle; that is the AND
    // of the lower wrap flags (a channel's wrap depends only on its own
    // registers), which keeps the enable free of any chain through
    // w_step itself.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        if (k == 0) begin : g_head
            assign w_step[k] = w_accept;
        end else begin : g_tail
            assign w_step[k] = w_accept && (!cascade_q || (&w_wrap[k-1:0]));
        end

        lfsr_channel #(
            .WIDTH (WIDTH),
            .POLY  (POLY)
        ) u_channel (
            .clk   (clk),
            .rst   (rst),
            .load  (w_load),
            .seed  (seed_data[k*WIDTH +: WIDTH]),
            .step  (w_step[k]),
            .state (w_state[k*WIDTH +: WIDTH]),
            .wrap  (w_wrap[k])
        );
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cascade_d = cascade_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        // Flags only the wraps of channels that actually stepped.
        wrap_d    = w_step & w_wrap;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d     = burst_len;
                    cascade_d = cascade;
                    cnt_d     = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // Saturates for unbounded bursts instead of wrapping.
                if (w_accept && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = w_cnt_inc;
                end
                // Completion outranks a coincident stop.
                if (w_last) begin
                    state_d = DONE;
                end else if (stop) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cascade_q <= 1'b0;
            len_q     <= '0;
            cnt_q     <= '0;
            wrap_q    <= '0;
        end else begin
            state_q   <= state_d;
            cascade_q <= cascade_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            wrap_q    <= wrap_d;
        end
    end

    // All outputs come from registers; out_ready only affects the next state.
    assign out_if.out_data  = w_state;
    assign out_if.out_valid = (state_q == RUN);
    assign out_if.wrap_out  = wrap_q;
    assign busy             = (state_q == RUN);
    assign done             = (state_q == DONE);

endmodule : lfsr_vector_gen
`default_nettype wire

// File: tb/tb_lfsr_vector_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_vector_gen
// Description : Self-checking bench for lfsr_vector_gen (WIDTH 4, NUM_CH 3,
//               POLY x^4+x^3+1). Bursts come from a table of
//               {seed, mode, length, ready pattern, expected end state};
//               accepted vectors are checked against a position-based
//               model of the period-15 sequence through a queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_vector_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        cascade;
    logic [15:0] burst_len;
    logic        seed_load;
    logic [11:0] seed_data;
    logic        busy;
    logic        done;

    lfsr_vector_gen_if #(.WIDTH(4), .NUM_CH(3)) bus ();

    lfsr_vector_gen #(
        .WIDTH  (4),
        .NUM_CH (3),
        .POLY   (4'b1100),
        .CNT_W  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .cascade   (cascade),
        .burst_len (burst_len),
        .seed_load (seed_load),
        .seed_data (seed_data),
        .busy      (busy),
        .done      (done),
        .out_if    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Period-15 sequence of x^4+x^3+1 starting from 1.
    logic [3:0]  seq_tbl [15];
    int          pos  [3];
    int          spos [3];
    logic [11:0] exp_q [$];

    typedef struct {
        logic [11:0] seed;
        bit          same;     // seed_load in the same cycle as start
        bit          casc;
        int          len;
        int          rmode;    // 0: ready=1, 1: 1,0,0,1,1..., 2: 1,1,0...
        bit          poke;     // start + seed_load pulsed while running
        logic [11:0] exp_end;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx_of(input logic [3:0] v);
        for (int i = 0; i < 15; i++) begin
            if (seq_tbl[i] == v) return i;
        end
        return 0;  // zero seed behaves as seed 1
    endfunction

    task automatic model_load(input logic [11:0] sd);
        for (int k = 0; k < 3; k++) begin
            spos[k] = idx_of(sd[k*4 +: 4]);
            pos[k]  = spos[k];
        end
    endtask

    function automatic logic [11:0] model_vec();
        return {seq_tbl[pos[2]], seq_tbl[pos[1]], seq_tbl[pos[0]]};
    endfunction

    task automatic model_step(input bit casc, output logic [2:0] w);
        bit carry;
        bit st;
        carry = 1'b1;
        for (int k = 0; k < 3; k++) begin
            st = (k == 0) ? 1'b1 : (casc ? carry : 1'b1);
            if (st) begin
                pos[k] = (pos[k] + 1) % 15;
                w[k]   = (pos[k] == spos[k]);
            end else begin
                w[k] = 1'b0;
            end
            carry = st && w[k];
        end
    endtask

    task automatic burst(input int len, input bit casc, input int rmode, input bit poke,
                         input int stop_after, input bit sl, input logic [11:0] sd);
        int          acc;
        int          cyc;
        int          limit;
        logic [2:0]  expw;
        logic [11:0] prev;
        logic [11:0] e;
        logic [11:0] d;
        bit          stalled;
        bit          fin;
        bit          stopped;
        bit          r;
        acc = 0; cyc = 0; expw = '0; prev = '0;
        stalled = 1'b0; fin = 1'b0; stopped = 1'b0;
        limit = ((len == 0) ? stop_after : len) * 4 + 20;

        start     = 1'b1;
        cascade   = casc;
        burst_len = 16'(len);
        if (sl) begin
            seed_load = 1'b1;
            seed_data = sd;
            model_load(sd);
        end
        tick();
        start     = 1'b0;
        seed_load = 1'b0;

        while (!fin && cyc < limit) begin
            chk("run_valid", 32'(bus.out_valid), 32'd1);
            chk("run_busy",  32'(busy),          32'd1);
            chk("run_done",  32'(done),          32'd0);
            chk("run_wrap",  32'(bus.wrap_out),  32'(expw));
            if (stalled) chk("stall_hold", 32'(bus.out_data), 32'(prev));

            case (rmode)
                1:       r = (cyc % 5 == 0) || (cyc % 5 >= 3);
                2:       r = (cyc % 3 != 2);
                default: r = 1'b1;
            endcase
            if (stop_after > 0 && acc == stop_after) begin
                stop    = 1'b1;
                r       = 1'b0;
                stopped = 1'b1;
            end
            if (poke && cyc == 1) begin
                start     = 1'b1;
                seed_load = 1'b1;
                seed_data = 12'h345;
            end
            bus.out_ready = r;

            if (r) begin
                exp_q.push_back(model_vec());
                model_step(casc, expw);
                e = exp_q.pop_front();
                d = bus.out_data;
                chk("data", 32'(d), 32'(e));
                chk("nonzero", 32'((d[3:0] != 0) && (d[7:4] != 0) && (d[11:8] != 0)), 32'd1);
                acc++;
            end else begin
                expw = '0;
            end
            stalled = !r;
            prev    = bus.out_data;

            tick();
            start = 1'b0; seed_load = 1'b0; stop = 1'b0;
            cyc++;
            if ((len != 0 && acc == len) || stopped) fin = 1'b1;
        end
        bus.out_ready = 1'b0;

        if (!fin) begin
            total++;
            bad++;
            $display("FAIL burst_timeout got=%0d accepts exp=%0d", acc, len);
        end else if (stopped) begin
            chk("stop_done",  32'(done),          32'd0);
            chk("stop_busy",  32'(busy),          32'd0);
            chk("stop_valid", 32'(bus.out_valid), 32'd0);
            tick();
            chk("stop_done2", 32'(done),          32'd0);
        end else begin
            chk("done_pulse", 32'(done),          32'd1);
            chk("done_busy",  32'(busy),          32'd0);
            chk("done_valid", 32'(bus.out_valid), 32'd0);
            chk("done_wrap",  32'(bus.wrap_out),  32'(expw));
            tick();
            chk("idle_done",  32'(done),          32'd0);
            chk("idle_valid", 32'(bus.out_valid), 32'd0);
            chk("idle_wrap",  32'(bus.wrap_out),  32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        seq_tbl = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                    4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
        //            seed    same casc len rmode poke end
        tbl[0] = '{12'h111, 1'b0, 1'b0, 15, 0, 1'b0, 12'h111};
        tbl[1] = '{12'h111, 1'b0, 1'b1, 16, 0, 1'b0, 12'h122};
        tbl[2] = '{12'h111, 1'b0, 1'b0,  3, 1, 1'b1, 12'h999};
        tbl[3] = '{12'h101, 1'b0, 1'b0,  4, 2, 1'b0, 12'h333};
        tbl[4] = '{12'h5A7, 1'b1, 1'b0, 20, 0, 1'b0, 12'hCE1};
        tbl[5] = '{12'h888, 1'b0, 1'b1, 30, 2, 1'b0, 12'h828};

        rst = 1'b1; start = 1'b0; stop = 1'b0; cascade = 1'b0;
        burst_len = '0; seed_load = 1'b0; seed_data = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_load(12'h111);

        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy",  32'(busy),          32'd0);
        chk("rst_done",  32'(done),          32'd0);
        chk("rst_wrap",  32'(bus.wrap_out),  32'd0);
        chk("rst_data",  32'(bus.out_data),  32'h111);

        for (int i = 0; i < 6; i++) begin
            if (!tbl[i].same) begin
                seed_load = 1'b1;
                seed_data = tbl[i].seed;
                tick();
                seed_load = 1'b0;
                model_load(tbl[i].seed);
                chk("seed_view", 32'(bus.out_data), 32'(model_vec()));
                burst(tbl[i].len, tbl[i].casc, tbl[i].rmode, tbl[i].poke, 0, 1'b0, 12'h0);
            end else begin
                burst(tbl[i].len, tbl[i].casc, tbl[i].rmode, tbl[i].poke, 0, 1'b1, tbl[i].seed);
            end
            chk("end_state", 32'(bus.out_data), 32'(tbl[i].exp_end));
        end

        // Unbounded burst stopped after 5 accepts, then resumed.
        seed_load = 1'b1;
        seed_data = 12'h111;
        tick();
        seed_load = 1'b0;
        model_load(12'h111);
        burst(0, 1'b0, 0, 1'b1, 5, 1'b0, 12'h0);
        chk("stop_state", 32'(bus.out_data), 32'h666);
        burst(2, 1'b0, 0, 1'b0, 0, 1'b0, 12'h0);
        chk("resume_end", 32'(bus.out_data), 32'hAAA);

        // Asynchronous reset while streaming.
        start = 1'b1; burst_len = '0; cascade = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_data",  32'(bus.out_data),  32'h111);
        chk("arst_busy",  32'(busy),          32'd0);
        chk("arst_done",  32'(done),          32'd0);
        chk("arst_wrap",  32'(bus.wrap_out),  32'd0);
        #2 rst = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("arst_nodone", 32'(done), 32'd0);
            chk("arst_idle",   32'(busy), 32'd0);
        end
        model_load(12'h111);
        burst(2, 1'b0, 0, 1'b0, 0, 1'b0, 12'h0);
        chk("arst_end", 32'(bus.out_data), 32'h444);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_lfsr_vector_gen
`default_nettype wire
